// File: rtl/apb_reg_slave_if.sv
// rtl/apb_reg_slave_if.sv - APB bus bundle between the bridge master port and a register slave
interface apb_reg_slave_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    modport master (
        output paddr, psel, penable, pwrite, pprot, pstrb, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pprot, pstrb, pwdata,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB register bank responder with wait states, byte strobes and PSLVERR
module apb_reg_slave #(
    parameter int  reg_n            = 8,
    parameter int  rw_reg_n         = 4,
    parameter int  wait_cycles      = 0,
    parameter bit  privileged_only  = 1'b0,
    parameter real simulation_delay = 1.0
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    apb_reg_slave_if.slave                                         s_apb,
    output logic [((rw_reg_n > 0) ? rw_reg_n : 1)*32-1:0]          reg_out,
    input  logic [((reg_n > rw_reg_n) ? reg_n - rw_reg_n : 1)*32-1:0] status_in,
    output logic [((rw_reg_n > 0) ? rw_reg_n : 1)-1:0]             wr_pulse
);
    localparam int         rw_n             = (rw_reg_n > 0) ? rw_reg_n : 1;
    localparam int         ro_n             = (reg_n > rw_reg_n) ? reg_n - rw_reg_n : 1;
    localparam logic [3:0] wait_init        = 4'(wait_cycles);
    // Zero-delay RTL; simulation_delay is accepted for interface compatibility only.
    localparam real        unused_sim_delay = simulation_delay;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_next;
    logic [9:0]  idx_q;
    logic        wr_q;
    logic [3:0]  cnt;
    logic        pready_q, pslverr_q;
    logic [31:0] prdata_q;
    logic [31:0] regs [rw_n];

    logic [9:0]  idx_in;
    logic        err_in;
    logic [31:0] rd_word;
    logic        do_setup, do_step, do_done, do_abort;
    logic        unused_bits;

    assign idx_in      = s_apb.paddr[11:2];
    assign unused_bits = ^{s_apb.paddr[31:12], s_apb.paddr[1:0], s_apb.pprot[2:1]};

    assign s_apb.pready  = pready_q;
    assign s_apb.pslverr = pslverr_q;
    assign s_apb.prdata  = prdata_q;

    // Access legality and read-word selection for the address presented at SETUP.
    always_comb begin
        err_in  = (int'(idx_in) >= reg_n)
                | (s_apb.pwrite & (int'(idx_in) >= rw_reg_n))
                | (privileged_only & ~s_apb.pprot[0]);
        rd_word = '0;
        for (int i = 0; i < rw_n; i++) begin
            if (i < rw_reg_n && int'(idx_in) == i) rd_word = regs[i];
        end
        for (int j = 0; j < ro_n; j++) begin
            if (j < reg_n - rw_reg_n && int'(idx_in) == rw_reg_n + j)
                rd_word = status_in[j*32 +: 32];
        end
    end

    // Next-state and transfer-phase decode.
    always_comb begin
        state_next = state;
        do_setup   = 1'b0;
        do_step    = 1'b0;
        do_done    = 1'b0;
        do_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (s_apb.psel && !s_apb.penable) begin
                    do_setup   = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!s_apb.psel) begin
                    do_abort   = 1'b1;
                    state_next = IDLE;
                end else if (s_apb.penable) begin
                    if (pready_q) begin
                        do_done    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        do_step    = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Transfer context and registered APB response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            wr_q      <= 1'b0;
            cnt       <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else if (do_setup) begin
            idx_q     <= idx_in;
            wr_q      <= s_apb.pwrite;
            cnt       <= wait_init;
            pready_q  <= (wait_cycles == 0);
            pslverr_q <= err_in;
            prdata_q  <= (s_apb.pwrite || err_in) ? 32'd0 : rd_word;
        end else if (do_step) begin
            cnt       <= cnt - 4'd1;
            pready_q  <= (cnt == 4'd1);
        end else if (do_done || do_abort) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end
    end

    // RW register bank: byte-strobed commit on a clean completion, one-cycle pulse per write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < rw_n; i++) regs[i] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (do_done && wr_q && !pslverr_q) begin
                for (int i = 0; i < rw_n; i++) begin
                    if (i < rw_reg_n && int'(idx_q) == i) begin
                        for (int k = 0; k < 4; k++) begin
                            if (s_apb.pstrb[k]) regs[i][8*k +: 8] <= s_apb.pwdata[8*k +: 8];
                        end
                        wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Fabric-side view of the RW registers.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < rw_n; i++) begin
            if (i < rw_reg_n) reg_out[i*32 +: 32] = regs[i];
        end
    end
endmodule
